apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter addrWidth, default 2, APB address width.
REQ-002 SHALL have parameter dataWidth, default 8, APB data width (matches slave timerbits).
REQ-003 SHALL have parameter timeoutCycles, default 16, ACCESS-cycle limit when timeout is compiled in.
REQ-004 SHALL have port clk  input  1  clock; all flops on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  command accepted this cycle.
REQ-008 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-009 SHALL have port cmd_addr  input  addrWidth  target address.
REQ-010 SHALL have port cmd_wdata  input  dataWidth  write data.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  response consumed.
REQ-013 SHALL have port rsp_rdata  output  dataWidth  read data (0 for writes).
REQ-014 SHALL have port rsp_err  output  1  slave error or timeout.
REQ-015 SHALL have ports sel, enable, write (1 each), addr (addrWidth), wdata (dataWidth)  outputs  APB request to slave.
REQ-016 SHALL have ports rdata (dataWidth), ready (1), slverr (1)  inputs  APB completion from slave.

Function
REQ-017 SHALL implement FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; all outputs registered.
REQ-018 IDLE: cmd_ready=1, sel=0, enable=0; cmd_valid high latches write/addr/wdata, next state SETUP.
REQ-019 SETUP: sel=1, enable=0 for exactly one cycle; next state ACCESS.
REQ-020 ACCESS: sel=1, enable=1; addr/write/wdata held stable from SETUP until exit.
REQ-021 ACCESS with ready=1: capture rdata (reads only, else 0) and slverr; next state RESP; sel/enable low in RESP.
REQ-022 ACCESS with ready=0: stay in ACCESS (wait states unlimited unless timeout compiled in).
REQ-023 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready=1; then IDLE.
REQ-024 cmd_ready SHALL be 1 only in IDLE; at most one transaction outstanding.
REQ-025 Minimum latency: accept cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3 when ready at N+2.
REQ-026 cmd_* changes outside IDLE SHALL be ignored.
REQ-027 rsp_ready=1 and cmd_valid=1 in RESP: response retires, new command accepted in following IDLE cycle only.

Reset
REQ-028 reset low SHALL asynchronously force IDLE; sel, enable, write, addr, wdata, rsp_valid, rsp_rdata, rsp_err = 0; cmd_ready = 1 after release.
REQ-029 Reset mid-transaction SHALL abort without producing a response.

Configuration
REQ-030 Macro APB_MASTER_TIMEOUT_EN defined: ACCESS cycle counter; reaching timeoutCycles without ready SHALL exit to RESP with rsp_err=1, rsp_rdata=0, sel/enable dropped.
REQ-031 Macro undefined: no counter, ACCESS waits indefinitely for ready.

Structure
REQ-032 Package apb_pkg SHALL hold the FSM state enum (IDLE=0, SETUP=1, ACCESS=2, RESP=3) and shared APB width constants.
REQ-033 Single module; no sub-module (timeout counter inline under macro).

Verification
REQ-034 Write addr=1 data=8'h20, slave ready first ACCESS cycle -> sel N+1, enable N+2, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
REQ-035 Read addr=2, slave ready after 3 wait states, rdata=8'h05 -> ACCESS held 4 cycles, rsp_rdata=8'h05.
REQ-036 Write addr=2, slave slverr=1 with ready -> rsp_err=1, FSM returns IDLE after rsp_ready.
REQ-037 rsp_ready held low 5 cycles with cmd_valid high -> rsp_valid stays 1, cmd_ready 0, no new SETUP.
REQ-038 reset low during ACCESS -> sel/enable 0 immediately, no rsp_valid, next command runs normally.
REQ-039 APB_MASTER_TIMEOUT_EN, timeoutCycles=16, ready never asserted -> rsp_err=1 after 16 ACCESS cycles.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state encoding and default APB widths for apb_master.
package apb_pkg;

    localparam int APB_ADDR_W = 2;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_master.sv
// apb_master: single-outstanding command -> APB transfer -> response bridge.
// All outputs come straight from flops. Optional build macro
// APB_MASTER_TIMEOUT_EN adds an ACCESS-phase cycle limit (timeoutCycles);
// without it ACCESS waits for the slave indefinitely.
module apb_master
    import apb_pkg::*;
#(
    parameter int addrWidth     = APB_ADDR_W,
    parameter int dataWidth     = APB_DATA_W,
    parameter int timeoutCycles = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 sel,
    output logic                 enable,
    output logic                 write,
    output logic [addrWidth-1:0] addr,
    output logic [dataWidth-1:0] wdata,
    input  logic [dataWidth-1:0] rdata,
    input  logic                 ready,
    input  logic                 slverr
);

    // A zero limit would make every access fail before the slave is sampled.
    if (timeoutCycles < 1) begin : g_cfg_chk
        $error("apb_master: timeoutCycles must be at least 1");
    end

    apb_state_e           state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 sel_q, sel_d;
    logic                 enable_q, enable_d;
    logic                 write_q, write_d;
    logic [addrWidth-1:0] addr_q, addr_d;
    logic [dataWidth-1:0] wdata_q, wdata_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(timeoutCycles + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

    // Next state and next registered outputs; every output is the value it
    // must show in the state being entered.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        sel_d       = sel_q;
        enable_d    = enable_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d       = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    sel_d       = 1'b1;
                    write_d     = cmd_write;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                end
            end
            SETUP: begin
                state_d  = ACCESS;
                enable_d = 1'b1;
            end
            ACCESS: begin
                if (ready) begin
                    state_d     = RESP;
                    sel_d       = 1'b0;
                    enable_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = write_q ? '0 : rdata;
                    rsp_err_d   = slverr;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                // cnt_q counts ACCESS cycles already spent without ready.
                else if (cnt_q == CNT_W'(timeoutCycles - 1)) begin
                    state_d     = RESP;
                    sel_d       = 1'b0;
                    enable_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                // New commands are only taken once back in IDLE.
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            sel_q       <= sel_d;
            enable_q    <= enable_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign sel       = sel_q;
    assign enable    = enable_q;
    assign write     = write_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed + randomized transactions against a timeline model.
// Each transaction's expected waveform is derived from phase lengths:
// accept at cycle 0, SETUP at 1, ACCESS for (waits+1) cycles, then RESP until
// rsp_ready. Build with APB_MASTER_TIMEOUT_EN to also cover the timeout.
module tb_apb_master;

    localparam int AW  = 2;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          sel, enable, apb_write;
    logic [AW-1:0] apb_addr;
    logic [DW-1:0] apb_wdata, rdata;
    logic          ready, slverr;

    int vectors     = 0;
    int miscompares = 0;

    apb_master #(.addrWidth(AW), .dataWidth(DW), .timeoutCycles(TMO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sel(sel), .enable(enable), .write(apb_write),
        .addr(apb_addr), .wdata(apb_wdata),
        .rdata(rdata), .ready(ready), .slverr(slverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one transaction starting in an IDLE cycle (entered at posedge+1).
    task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input int w, input logic [DW-1:0] rd, input bit se, input int d);
        int acc_len, rv_start, last;
        bit tmo;
        tmo     = 1'b0;
        acc_len = w + 1;
`ifdef APB_MASTER_TIMEOUT_EN
        if (acc_len > TMO) begin
            acc_len = TMO;
            tmo     = 1'b1;
        end
`endif
        rv_start = 2 + acc_len;
        last     = rv_start + d;
        for (int c = 0; c <= last; c++) begin
            if (c == 0) begin
                cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
            end else begin
                // Junk on the command port must be ignored outside IDLE.
                cmd_valid = (c >= rv_start) ? 1'b1 : 1'($urandom);
                cmd_write = 1'($urandom);
                cmd_addr  = AW'($urandom);
                cmd_wdata = DW'($urandom);
            end
            if (c >= 2 && c < rv_start) ready = (c == 2 + w) && !tmo;
            else                        ready = 1'($urandom);
            rdata     = ready ? rd : DW'($urandom);
            slverr    = ready ? se : 1'($urandom);
            rsp_ready = (c == last) ? 1'b1 : ((c < rv_start) ? 1'($urandom) : 1'b0);
            @(negedge clk);
            chk("cmd_ready", 32'(cmd_ready), 32'(c == 0));
            chk("sel",       32'(sel),       32'(c >= 1 && c < rv_start));
            chk("enable",    32'(enable),    32'(c >= 2 && c < rv_start));
            chk("rsp_valid", 32'(rsp_valid), 32'(c >= rv_start));
            if (c >= 1 && c < rv_start) begin
                chk("addr",  32'(apb_addr),  32'(a));
                chk("write", 32'(apb_write), 32'(wr));
                chk("wdata", 32'(apb_wdata), 32'(wd));
            end
            if (c >= rv_start) begin
                chk("rsp_rdata", 32'(rsp_rdata), (wr || tmo) ? 32'h0 : 32'(rd));
                chk("rsp_err",   32'(rsp_err),   32'(tmo || se));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; rdata = '0; ready = 1'b0; slverr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sel",       32'(sel),       32'h0);
        chk("rst_enable",    32'(enable),    32'h0);
        chk("rst_write",     32'(apb_write), 32'h0);
        chk("rst_addr",      32'(apb_addr),  32'h0);
        chk("rst_wdata",     32'(apb_wdata), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        chk("rst_rsp_err",   32'(rsp_err),   32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Write, zero wait states: minimum latency
        run_txn(1'b1, 2'd1, 8'h20, 0, 8'h00, 1'b0, 0);
        // Read with 3 wait states
        run_txn(1'b0, 2'd2, 8'h00, 3, 8'h05, 1'b0, 0);
        // Write with slave error
        run_txn(1'b1, 2'd2, 8'h77, 0, 8'h00, 1'b1, 1);
        // Response held 5 cycles while cmd_valid stays high
        run_txn(1'b0, 2'd3, 8'h00, 1, 8'hA5, 1'b0, 5);

        // Reset during ACCESS aborts the transfer
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd1; cmd_wdata = 8'h3C;
        ready = 1'b0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_enable", 32'(enable), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_sel",       32'(sel),       32'h0);
        chk("mid_rst_enable",    32'(enable),    32'h0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);
            chk("post_rst_sel",       32'(sel),       32'h0);
        end
        @(posedge clk); #1;
        run_txn(1'b1, 2'd0, 8'h5A, 2, 8'h00, 1'b0, 0);

`ifdef APB_MASTER_TIMEOUT_EN
        // Slave never answers: timeout after TMO ACCESS cycles
        run_txn(1'b0, 2'd1, 8'h00, 40, 8'hFF, 1'b0, 1);
`endif

        // Randomized transactions
        for (int t = 0; t < 25; t++) begin
            run_txn(1'($urandom), AW'($urandom), DW'($urandom),
                    int'($urandom_range(0, 6)), DW'($urandom),
                    ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
        end

        // Final idle check
        cmd_valid = 1'b0; ready = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        chk("final_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("final_rsp_valid", 32'(rsp_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
